// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC121S101-class SPI transmitter.
// Frame layout: {2'b00, pd[1:0], sample[11:0]}, sent MSB first.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int DAC_BITS   = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [1:0] pd,
                                                       input logic [DAC_BITS-1:0] sample);
    return {2'b00, pd, sample};
  endfunction

endpackage

// File: rtl/dac_spi_tx_clk_gen.sv
// SCLK divider for the DAC transmitter: runs only while enabled, reports the
// sclk level for the next cycle plus bit-boundary and last-bit strobes.
module spi_clk_gen
  import dac_spi_pkg::*;
#(
  parameter int DIV_LOG2 = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_nxt_o,
  output logic bit_stb_o,
  output logic last_stb_o
);

  localparam logic [DIV_LOG2-1:0] DIV_ONE = 1;

  logic [DIV_LOG2-1:0] div_q;
  logic [DIV_LOG2-1:0] div_nxt;
  logic [4:0]          bit_q;

  // div_q is the phase of the current cycle within its bit period; the first
  // half of every period drives sclk high, the second half low.
  assign div_nxt    = div_q + DIV_ONE;
  assign bit_stb_o  = en_i & (&div_q);
  assign last_stb_o = bit_stb_o & (bit_q == 5'(FRAME_BITS - 1));
  assign sclk_nxt_o = ~en_i | ~div_nxt[DIV_LOG2-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      bit_q <= '0;
    end else if (!en_i) begin
      div_q <= '0;
      bit_q <= '0;
    end else begin
      div_q <= div_nxt;
      if (bit_stb_o) bit_q <= bit_q + 5'd1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master writing 16-bit frames to a 12-bit serial DAC (PmodDA2-style).
// Handshake: a word transfers on a rising clk edge where valid and ready are both 1.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int DIV_LOG2   = 5,
  parameter int DATA_W     = 12,
  parameter int GAP_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        pd,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              sync,
  output logic              mosi,
  output logic [1:0]        dbg_state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] word;
  logic [GW-1:0]         gap_q, gap_d;
  logic sclk_q, sclk_d, sync_q, sync_d, mosi_q, mosi_d;
  logic ready_q, ready_d, done_q, done_d;
  logic sclk_nxt, bit_stb, last_stb;

  assign word = pack_frame(pd, din);

  spi_clk_gen #(.DIV_LOG2(DIV_LOG2)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q == SHIFT),
    .sclk_nxt_o (sclk_nxt),
    .bit_stb_o  (bit_stb),
    .last_stb_o (last_stb)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          state_d = SHIFT;
          frame_d = word;
          mosi_d  = word[FRAME_BITS-1];
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SHIFT: begin
        sclk_d = sclk_nxt;
        if (last_stb) begin
          state_d = GAP;
          sync_d  = 1'b1;
          sclk_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          gap_d   = '0;
        end else if (bit_stb) begin
          // frame_q[15] is already on the wire, so the next bit sits at [14]
          mosi_d  = frame_q[FRAME_BITS-2];
          frame_d = frame_q << 1;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign sync      = sync_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance (DIV=32) and a fast one (DIV=4).
// A negedge monitor decodes frames from the pins and scores them against exp_q.
module tb_dac_spi_tx;
  import dac_spi_pkg::*;

  localparam int GAP  = 32;
  localparam int DIV0 = 32;
  localparam int DIV1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] din_a   [2];
  logic [1:0]  pd_a    [2];
  logic        valid_a [2];
  logic        ready_a [2];
  logic        done_a  [2];
  logic        sclk_a  [2];
  logic        sync_a  [2];
  logic        mosi_a  [2];
  logic [1:0]  dbg_a   [2];

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int frames_exp [2];
  logic b2b = 1'b0;

  always #5 clk = ~clk;

  dac_spi_tx dut (
    .clk(clk), .rst(rst), .din(din_a[0]), .pd(pd_a[0]), .valid(valid_a[0]),
    .ready(ready_a[0]), .done(done_a[0]), .sclk(sclk_a[0]), .sync(sync_a[0]),
    .mosi(mosi_a[0]), .dbg_state(dbg_a[0])
  );

  dac_spi_tx #(.DIV_LOG2(2)) dut_fast (
    .clk(clk), .rst(rst), .din(din_a[1]), .pd(pd_a[1]), .valid(valid_a[1]),
    .ready(ready_a[1]), .done(done_a[1]), .sclk(sclk_a[1]), .sync(sync_a[1]),
    .mosi(mosi_a[1]), .dbg_state(dbg_a[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the DAC sees two zero bits, the power-down pair, then the sample.
  function automatic logic [15:0] model(input logic [11:0] d, input logic [1:0] p);
    int w;
    w = int'(p) * 4096 + int'(d);
    return 16'(w);
  endfunction

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  task automatic push(input int k, input logic [15:0] w);
    if (k == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
    frames_exp[k]++;
  endtask

  task automatic send(input int k, input logic [11:0] d, input logic [1:0] p);
    int n = 0;
    @(negedge clk);
    din_a[k] = d; pd_a[k] = p; valid_a[k] = 1'b1;
    while (!ready_a[k] && n < 3000) begin @(negedge clk); n++; end
    check("send_ready", int'(ready_a[k]), 1);
    if (ready_a[k]) push(k, model(d, p));
    @(negedge clk);
    valid_a[k] = 1'b0;
    din_a[k] = 12'($urandom);
    pd_a[k]  = 2'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    @(negedge clk);
    while (!(ready_a[k] && sync_a[k]) && n < 3000) begin @(negedge clk); n++; end
    check("wait_idle", int'(ready_a[k] && sync_a[k]), 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int low_cnt [2], falls [2], run [2], run_bad [2], rdy_bad [2], done_in [2];
  int gap_cnt [2], idle_bad [2], frames_seen [2];
  logic [15:0] word [2];
  logic prev_sync [2], prev_sclk [2], in_frame [2], have_prev [2];
  logic [15:0] e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        in_frame[k]  = 1'b0;
        have_prev[k] = 1'b0;
        prev_sync[k] = 1'b1;
        prev_sclk[k] = 1'b1;
        gap_cnt[k]   = 1000;
      end else begin
        if (prev_sync[k] && !sync_a[k]) begin
          if (b2b && have_prev[k]) check("b2b_sync_high_cycles", gap_cnt[k], GAP + 1);
          in_frame[k] = 1'b1;
          low_cnt[k] = 0; falls[k] = 0; run[k] = 0; run_bad[k] = 0;
          rdy_bad[k] = 0; done_in[k] = 0; word[k] = '0;
        end
        if (!sync_a[k]) begin
          if (in_frame[k]) begin
            low_cnt[k]++;
            if (ready_a[k]) rdy_bad[k]++;
            if (done_a[k]) done_in[k]++;
            if (low_cnt[k] == 1) begin
              run[k] = 1;
              if (!sclk_a[k]) run_bad[k]++;
            end else if (sclk_a[k] == prev_sclk[k]) begin
              run[k]++;
            end else begin
              if (run[k] != div_of(k) / 2) run_bad[k]++;
              run[k] = 1;
              if (!sclk_a[k]) begin
                word[k] = {word[k][14:0], mosi_a[k]};
                falls[k]++;
              end
            end
          end
        end else if (!prev_sync[k] && in_frame[k]) begin
          if (prev_sclk[k] || run[k] != div_of(k) / 2) run_bad[k]++;
          if (ready_a[k]) rdy_bad[k]++;
          check("done_at_sync_rise", int'(done_a[k]), 1);
          check("exp_available", int'((k == 0 ? exp_q0.size() : exp_q1.size()) > 0), 1);
          if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
          else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
          else e = 16'hxxxx;
          check("frame_word", int'(word[k]), int'(e));
          check("sync_low_cycles", low_cnt[k], 16 * div_of(k));
          check("sclk_falls", falls[k], 16);
          check("sclk_half_periods", run_bad[k], 0);
          check("ready_low_in_frame", rdy_bad[k], 0);
          check("no_done_mid_frame", done_in[k], 0);
          in_frame[k]  = 1'b0;
          have_prev[k] = b2b;
          gap_cnt[k]   = 1;
          frames_seen[k]++;
        end else begin
          if (gap_cnt[k] < 1000) gap_cnt[k]++;
          if (done_a[k]) idle_bad[k]++;
          if (ready_a[k] != (gap_cnt[k] > GAP)) idle_bad[k]++;
        end
        if (sync_a[k] && (!sclk_a[k] || mosi_a[k])) idle_bad[k]++;
        prev_sync[k] = sync_a[k];
        prev_sclk[k] = sclk_a[k];
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad, edges, cnt, nfr, guard;
    logic last_sclk [2];
    for (int k = 0; k < 2; k++) begin
      din_a[k] = '0; pd_a[k] = '0; valid_a[k] = 1'b0;
      frames_exp[k] = 0; frames_seen[k] = 0; idle_bad[k] = 0;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;

    // Idle after reset: outputs at reset values, no sclk activity
    bad = 0; edges = 0;
    for (int k = 0; k < 2; k++) last_sclk[k] = sclk_a[k];
    for (int k = 0; k < 2; k++) begin
      check("rst_sclk", int'(sclk_a[k]), 1);
      check("rst_sync", int'(sync_a[k]), 1);
      check("rst_ready", int'(ready_a[k]), 1);
      check("rst_state", int'(dbg_a[k]), int'(IDLE));
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!sclk_a[k] || !sync_a[k] || mosi_a[k] || !ready_a[k] || done_a[k]) bad++;
        if (sclk_a[k] != last_sclk[k]) edges++;
        last_sclk[k] = sclk_a[k];
      end
    end
    check("idle_outputs", bad, 0);
    check("idle_sclk_edges", edges, 0);

    // Directed frames
    send(0, 12'hA5C, PD_NORMAL); wait_idle(0);
    send(0, 12'h000, PD_HIZ);    wait_idle(0);
    send(0, 12'hFFF, PD_NORMAL); wait_idle(0);

    // Random frames
    for (int i = 0; i < 4; i++) begin
      send(0, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
      wait_idle(0);
    end

    // Back-to-back with valid held and din counting; garbage on din/pd mid-frame
    b2b = 1'b1; cnt = 0; nfr = 0; guard = 0;
    while (nfr < 5 && guard < 6000) begin
      @(negedge clk); guard++;
      if (ready_a[0]) begin
        din_a[0] = 12'(cnt); pd_a[0] = PD_NORMAL; valid_a[0] = 1'b1;
        push(0, model(12'(cnt), PD_NORMAL));
        cnt++; nfr++;
      end else begin
        din_a[0] = 12'($urandom); pd_a[0] = 2'($urandom);
      end
    end
    check("b2b_frames_issued", nfr, 5);
    @(negedge clk);
    valid_a[0] = 1'b0;
    wait_idle(0);
    b2b = 1'b0;

    // Reset mid-frame while sclk is low
    send(0, 12'h5A3, PD_1K);
    repeat (199) @(negedge clk);
    guard = 0;
    while (sclk_a[0] && guard < 64) begin @(negedge clk); guard++; end
    check("abort_in_frame", int'(!sync_a[0] && !sclk_a[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_sync", int'(sync_a[0]), 1);
    check("async_rst_sclk", int'(sclk_a[0]), 1);
    check("async_rst_mosi", int'(mosi_a[0]), 0);
    check("async_rst_ready", int'(ready_a[0]), 1);
    check("async_rst_done", int'(done_a[0]), 0);
    frames_exp[0] -= exp_q0.size();
    exp_q0.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    send(0, 12'h123, PD_NORMAL); wait_idle(0);

    // Fast divider instance
    send(1, 12'hA5C, PD_NORMAL); wait_idle(1);
    for (int i = 0; i < 3; i++) begin
      send(1, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
      wait_idle(1);
    end

    repeat (10) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    for (int k = 0; k < 2; k++) begin
      check("frames_seen", frames_seen[k], frames_exp[k]);
      check("idle_invariants", idle_bad[k], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout, want finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
